ra_search_ctrl: RTL and testbench

- Sequencer for the spare-allocation candidate search in the redundancy-analysis path.
- Resets and steps the spare-selection signal generator one candidate at a time.
- Hands each DSSS/RLSS candidate to the fault-coverage analyzer over a valid/ready handshake and collects pass/fail.
- Stops on the first passing candidate, on exhaustion, or on analyzer timeout, then reports the result.

---
 rtl/ra_search_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_ra_search_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ra_search_ctrl.sv
// Spare-allocation candidate search sequencer.
// Walks the spare-selection generator one candidate at a time, offers each candidate to the
// fault-coverage analyzer over valid/ready, and stops on the first pass, on exhaustion or on
// an analyzer timeout. All outputs are registered and change together with the state.
module ra_search_ctrl #(
  parameter int unsigned CNT_W       = 9,
  parameter int unsigned MAX_CAND    = 420,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       spare_struct_type,
  output logic             gen_rst,
  output logic             gen_step,
  input  logic [7:0]       gen_dsss,
  input  logic [3:0]       gen_rlss,
  input  logic             gen_last,
  output logic             ana_valid,
  output logic [7:0]       ana_dsss,
  output logic [3:0]       ana_rlss,
  input  logic             ana_ready,
  input  logic             ana_resp_valid,
  input  logic             ana_pass,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [CNT_W-1:0] cand_cnt,
  output logic [7:0]       best_dsss,
  output logic [3:0]       best_rlss
);

  localparam int unsigned ToW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] MaxCand = CNT_W'(MAX_CAND);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StLoad,
    StIssue,
    StWait,
    StNext,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       type_q, type_d;
  logic             last_q, last_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic             gen_rst_q, gen_rst_d;
  logic             gen_step_q, gen_step_d;
  logic             ana_valid_q, ana_valid_d;
  logic [7:0]       ana_dsss_q, ana_dsss_d;
  logic [3:0]       ana_rlss_q, ana_rlss_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cand_cnt_q, cand_cnt_d;
  logic [7:0]       best_dsss_q, best_dsss_d;
  logic [3:0]       best_rlss_q, best_rlss_d;

  logic [CNT_W-1:0] cand_inc;
  logic             to_expired;

  // Saturating response count and timeout detection for the current WAIT cycle.
  always_comb begin
    cand_inc   = (cand_cnt_q >= MaxCand) ? cand_cnt_q : cand_cnt_q + CNT_W'(1);
    to_expired = ((32'(to_cnt_q) + 32'd1) >= TIMEOUT_CYC);
  end

  // Next-state and registered-output computation; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    last_d      = last_q;
    to_cnt_d    = to_cnt_q;
    gen_rst_d   = 1'b0;
    gen_step_d  = 1'b0;
    ana_valid_d = 1'b0;
    ana_dsss_d  = ana_dsss_q;
    ana_rlss_d  = ana_rlss_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    found_d     = found_q;
    err_d       = err_q;
    cand_cnt_d  = cand_cnt_q;
    best_dsss_d = best_dsss_q;
    best_rlss_d = best_rlss_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          found_d     = 1'b0;
          err_d       = 1'b0;
          cand_cnt_d  = '0;
          best_dsss_d = '0;
          best_rlss_d = '0;
          busy_d      = 1'b1;
          if (spare_struct_type == 2'b00) begin
            // Invalid structure type: report straight away, generator untouched.
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            type_d    = spare_struct_type;
            gen_rst_d = 1'b1;
            state_d   = StInit;
          end
        end
      end

      StInit: begin
        // Generator output becomes valid in LOAD, one cycle after the reset pulse.
        state_d = StLoad;
      end

      StLoad: begin
        ana_dsss_d  = gen_dsss;
        ana_rlss_d  = (type_q == 2'b11) ? gen_rlss : 4'b0000;
        last_d      = gen_last;
        ana_valid_d = 1'b1;
        state_d     = StIssue;
      end

      StIssue: begin
        if (ana_ready) begin
          to_cnt_d = '0;
          state_d  = StWait;
        end else begin
          ana_valid_d = 1'b1;
        end
      end

      StWait: begin
        to_cnt_d = to_cnt_q + ToW'(1);
        if (ana_resp_valid) begin
          cand_cnt_d = cand_inc;
          if (ana_pass) begin
            found_d     = 1'b1;
            best_dsss_d = ana_dsss_q;
            best_rlss_d = ana_rlss_q;
            done_d      = 1'b1;
            state_d     = StDone;
          end else if (last_q || (cand_inc == MaxCand)) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            gen_step_d = 1'b1;
            state_d    = StNext;
          end
        end else if (to_expired) begin
          // Analyzer never answered: abort without counting this candidate.
          err_d   = 1'b1;
          found_d = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end

      StNext: begin
        state_d = StLoad;
      end

      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Single state/output register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      type_q      <= 2'b00;
      last_q      <= 1'b0;
      to_cnt_q    <= '0;
      gen_rst_q   <= 1'b0;
      gen_step_q  <= 1'b0;
      ana_valid_q <= 1'b0;
      ana_dsss_q  <= '0;
      ana_rlss_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
      cand_cnt_q  <= '0;
      best_dsss_q <= '0;
      best_rlss_q <= '0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      last_q      <= last_d;
      to_cnt_q    <= to_cnt_d;
      gen_rst_q   <= gen_rst_d;
      gen_step_q  <= gen_step_d;
      ana_valid_q <= ana_valid_d;
      ana_dsss_q  <= ana_dsss_d;
      ana_rlss_q  <= ana_rlss_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
      err_q       <= err_d;
      cand_cnt_q  <= cand_cnt_d;
      best_dsss_q <= best_dsss_d;
      best_rlss_q <= best_rlss_d;
    end
  end

  assign gen_rst   = gen_rst_q;
  assign gen_step  = gen_step_q;
  assign ana_valid = ana_valid_q;
  assign ana_dsss  = ana_dsss_q;
  assign ana_rlss  = ana_rlss_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign err       = err_q;
  assign cand_cnt  = cand_cnt_q;
  assign best_dsss = best_dsss_q;
  assign best_rlss = best_rlss_q;

endmodule

// File: tb/tb_ra_search_ctrl.sv
// Bench for ra_search_ctrl: generator and analyzer models, scoreboard of expected results
// pushed per search and popped by a monitor on each done pulse.
module tb_ra_search_ctrl;

  localparam int Big = 100000;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] spare_struct_type;
  logic       gen_rst, gen_step, gen_last;
  logic [7:0] gen_dsss;
  logic [3:0] gen_rlss;
  logic       ana_valid, ana_ready, ana_resp_valid, ana_pass;
  logic [7:0] ana_dsss, best_dsss;
  logic [3:0] ana_rlss, best_rlss;
  logic       busy, done, found, err;
  logic [8:0] cand_cnt;

  always #5 clk = ~clk;

  ra_search_ctrl #(.CNT_W(9), .MAX_CAND(420), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst(rst), .start(start), .spare_struct_type(spare_struct_type),
    .gen_rst(gen_rst), .gen_step(gen_step), .gen_dsss(gen_dsss), .gen_rlss(gen_rlss),
    .gen_last(gen_last), .ana_valid(ana_valid), .ana_dsss(ana_dsss), .ana_rlss(ana_rlss),
    .ana_ready(ana_ready), .ana_resp_valid(ana_resp_valid), .ana_pass(ana_pass),
    .busy(busy), .done(done), .found(found), .err(err), .cand_cnt(cand_cnt),
    .best_dsss(best_dsss), .best_rlss(best_rlss)
  );

  typedef struct packed {
    logic       found;
    logic       err;
    logic [8:0] cnt;
    logic [7:0] dsss;
    logic [3:0] rlss;
  } exp_t;

  exp_t sbq[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Bench-side knobs and observations.
  logic [1:0] gen_type;
  int pass_at, resp_limit, stall_cyc;
  int n_issued, step_cnt, rst_cnt, done_cnt, excl_bad, stall_seen, stall_bad;
  logic [7:0] first_dsss;
  logic [3:0] rlss_seq[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
  endtask

  function automatic exp_t mk(input logic f, input logic e, input int c, input logic [7:0] d,
                              input logic [3:0] r);
    exp_t x;
    x.found = f;
    x.err   = e;
    x.cnt   = 9'(c);
    x.dsss  = d;
    x.rlss  = r;
    return x;
  endfunction

  // Generator model: 4-of-8 DSSS codes descending, RLSS 2-of-4 codes descending as inner loop.
  logic [7:0] dsss_tab[70];
  logic [3:0] rlss_tab[6];
  initial begin
    int di, ri, k;
    logic r, s;
    k = 0;
    for (int v = 255; v >= 0; v--) begin
      if ($countones(8'(v)) == 4) begin
        dsss_tab[k] = 8'(v);
        k++;
      end
    end
    k = 0;
    for (int v = 15; v >= 0; v--) begin
      if ($countones(4'(v)) == 2) begin
        rlss_tab[k] = 4'(v);
        k++;
      end
    end
    di = 0;
    ri = 0;
    gen_dsss = 8'h00;
    gen_rlss = 4'h0;
    gen_last = 1'b0;
    forever begin
      @(negedge clk);
      r = gen_rst;
      s = gen_step;
      @(posedge clk);
      #1;
      if (r) begin
        di = 0;
        ri = 0;
      end else if (s) begin
        if (gen_type == 2'b11 && ri < 5) ri++;
        else begin
          ri = 0;
          if (di < 69) di++;
        end
      end
      if (r || s) begin
        gen_dsss = dsss_tab[di];
        gen_rlss = rlss_tab[ri];
        gen_last = (di == 69) && (gen_type != 2'b11 || ri == 5);
      end
    end
  end

  // Analyzer model: optional stall on the first candidate, response one cycle after accept.
  initial begin
    logic [7:0] d0;
    logic [3:0] r0;
    ana_ready = 1'b0;
    ana_resp_valid = 1'b0;
    ana_pass = 1'b0;
    forever begin
      @(negedge clk);
      if (ana_valid === 1'b1) begin
        if (n_issued == 0) first_dsss = ana_dsss;
        if (n_issued < 6) rlss_seq[n_issued] = ana_rlss;
        if (n_issued == 0 && stall_cyc > 0) begin
          d0 = ana_dsss;
          r0 = ana_rlss;
          for (int k = 0; k < stall_cyc; k++) begin
            @(negedge clk);
            stall_seen++;
            if (!(ana_valid === 1'b1 && ana_dsss == d0 && ana_rlss == r0)) stall_bad++;
          end
        end
        ana_ready = 1'b1;
        @(posedge clk);
        #1;
        ana_ready = 1'b0;
        n_issued++;
        if (n_issued <= resp_limit) begin
          ana_resp_valid = 1'b1;
          ana_pass = (n_issued == pass_at);
          @(posedge clk);
          #1;
          ana_resp_valid = 1'b0;
          ana_pass = 1'b0;
        end
      end
    end
  end

  // Monitor: pulse counting, output exclusivity, scoreboard compare on done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (gen_step === 1'b1) step_cnt++;
      if (gen_rst === 1'b1) rst_cnt++;
      if (int'(gen_rst) + int'(gen_step) + int'(ana_valid) > 1) excl_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected_done: got done pulse, expected none");
        end else begin
          e = sbq.pop_front();
          check("sb_found", 32'(found), 32'(e.found));
          check("sb_err", 32'(err), 32'(e.err));
          check("sb_cand_cnt", 32'(cand_cnt), 32'(e.cnt));
          check("sb_best_dsss", 32'(best_dsss), 32'(e.dsss));
          check("sb_best_rlss", 32'(best_rlss), 32'(e.rlss));
        end
      end
    end
  end

  task automatic clear_obs();
    n_issued   = 0;
    step_cnt   = 0;
    rst_cnt    = 0;
    done_cnt   = 0;
    stall_seen = 0;
    stall_bad  = 0;
    first_dsss = 8'h00;
  endtask

  task automatic run(input logic [1:0] typ, input int pass_i, input int lim_i, input int stall_i,
                     input exp_t e, input bit inject, input string tag);
    bit got;
    gen_type   = typ;
    pass_at    = pass_i;
    resp_limit = lim_i;
    stall_cyc  = stall_i;
    clear_obs();
    sbq.push_back(e);
    @(posedge clk);
    #1;
    spare_struct_type = typ;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (inject && i == 10) begin
        spare_struct_type = 2'b01;
        start = 1'b1;
      end
      if (i == 11) start = 1'b0;
      if (done_cnt != 0) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    if (!got && sbq.size() != 0) void'(sbq.pop_front());
    repeat (2) @(negedge clk);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    spare_struct_type = 2'b00;
    gen_type = 2'b01;
    pass_at = 0;
    resp_limit = 0;
    stall_cyc = 0;
    excl_bad = 0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_found_err", 32'({found, err}), 32'd0);
    check("rst_cand_cnt", 32'(cand_cnt), 32'd0);
    check("rst_pulses", 32'({gen_rst, gen_step, ana_valid}), 32'd0);
    check("rst_ana_data", 32'({ana_dsss, ana_rlss, best_dsss, best_rlss}), 32'd0);

    run(2'b01, 3, Big, 0, mk(1'b1, 1'b0, 3, 8'hE4, 4'h0), 1'b0, "t1_pass3");
    check("t1_step_pulses", 32'(step_cnt), 32'd2);
    check("t1_rst_pulses", 32'(rst_cnt), 32'd1);

    run(2'b11, 7, Big, 0, mk(1'b1, 1'b0, 7, 8'hE8, 4'hC), 1'b0, "t2_pass7");
    check("t2_rlss_seq", 32'({rlss_seq[0], rlss_seq[1], rlss_seq[2], rlss_seq[3], rlss_seq[4],
                              rlss_seq[5]}), 32'h00CA9653);

    run(2'b01, 0, Big, 0, mk(1'b0, 1'b0, 70, 8'h00, 4'h0), 1'b0, "t3_exh70");
    check("t3_step_pulses", 32'(step_cnt), 32'd69);

    run(2'b11, 0, Big, 0, mk(1'b0, 1'b0, 420, 8'h00, 4'h0), 1'b0, "t4_exh420");

    run(2'b01, 1, Big, 10, mk(1'b1, 1'b0, 1, 8'hF0, 4'h0), 1'b0, "t5_stall");
    check("t5_stall_cycles", 32'(stall_seen), 32'd10);
    check("t5_stall_stable", 32'(stall_bad), 32'd0);

    run(2'b01, 0, 0, 0, mk(1'b0, 1'b1, 0, 8'h00, 4'h0), 1'b0, "t6_timeout");
    check("t6_issued", 32'(n_issued), 32'd1);

    // Invalid type: done in the cycle right after the start cycle, generator never reset.
    clear_obs();
    sbq.push_back(mk(1'b0, 1'b1, 0, 8'h00, 4'h0));
    @(posedge clk);
    #1;
    spare_struct_type = 2'b00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("t7_done_timing", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    check("t7_no_gen_rst", 32'(rst_cnt), 32'd0);
    check("t7_done_once", 32'(done_cnt), 32'd1);
    check("t7_busy_low", 32'(busy), 32'd0);

    // Second start with a different type mid-search must be ignored.
    run(2'b11, 7, Big, 0, mk(1'b1, 1'b0, 7, 8'hE8, 4'hC), 1'b1, "t8_start_busy");
    check("t8_rst_pulses", 32'(rst_cnt), 32'd1);

    // Reset in WAIT of the 6th candidate after five failed responses.
    gen_type = 2'b01;
    pass_at = 0;
    resp_limit = 5;
    stall_cyc = 0;
    clear_obs();
    @(posedge clk);
    #1;
    spare_struct_type = 2'b01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (n_issued == 6 && cand_cnt == 9'd5) begin
          hit = 1'b1;
          break;
        end
      end
      check("t9_reached_wait", 32'(hit), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t9_busy", 32'(busy), 32'd0);
    check("t9_cand_cnt", 32'(cand_cnt), 32'd0);
    check("t9_found", 32'(found), 32'd0);
    check("t9_pulses", 32'({gen_step, ana_valid}), 32'd0);
    repeat (3) @(negedge clk);
    check("t9_no_done", 32'(done_cnt), 32'd0);

    run(2'b01, 1, Big, 0, mk(1'b1, 1'b0, 1, 8'hF0, 4'h0), 1'b0, "t10_fresh");
    check("t10_first_dsss", 32'(first_dsss), 32'hF0);

    check("excl_pulses", 32'(excl_bad), 32'd0);
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
